// File: rtl/imem_boot_loader.sv
// Instruction memory for the SimpleRisc core: streams a boot image in while the
// core is stalled, then serves registered fetches with bounds/alignment checks.
module imem_boot_loader #(
   parameter int          DATA_W     = 32,
   parameter int          DEPTH      = 256,
   parameter int          ADDR_W     = 32,
   parameter bit          BYTE_ADDR  = 1'b1,
   parameter bit          SKIP_LOAD  = 1'b0,
   parameter logic [31:0] FILL_INSTR = 32'hF800_0000
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_load_valid,
   input  logic [DATA_W-1:0] i_load_data,
   input  logic              i_load_last,
   output logic              o_load_ready,
   input  logic              i_reload,
   output logic              o_boot_done,
   output logic              o_core_stall,
   input  logic              i_fetch_req,
   input  logic [ADDR_W-1:0] i_fetch_addr,
   output logic              o_fetch_valid,
   output logic [DATA_W-1:0] o_fetch_instr,
   output logic              o_fetch_err
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [CNT_W-1:0]  r_load_count;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_beat;
   logic              w_reload_run;
   logic              w_fetch_acc;
   logic [ADDR_W-1:0] w_idx;
   logic              w_err;

   assign o_load_ready = (r_state == ST_LOAD);
   assign o_boot_done  = (r_state == ST_RUN);
   assign o_core_stall = ~o_boot_done;

   assign w_beat       = i_load_valid && o_load_ready;
   assign w_reload_run = i_reload && (r_state == ST_RUN);
   // Reload wins over a same-cycle fetch so the core never sees stale data.
   assign w_fetch_acc  = i_fetch_req && (r_state == ST_RUN) && !i_reload;

   // Index and bound checks stay at full address width: any high bit is out of range.
   assign w_idx = BYTE_ADDR ? (i_fetch_addr >> 2) : i_fetch_addr;
   assign w_err = (BYTE_ADDR && (i_fetch_addr[1:0] != 2'b00))
                || (w_idx >= ADDR_W'(DEPTH))
                || (w_idx >= ADDR_W'(r_load_count));

   always_comb begin
      // NOTE: next state defaults to current state first so no latch is inferred.
      w_state_next = r_state;
      case (r_state)
         ST_LOAD: if (w_beat && (i_load_last || (r_wr_ptr == PTR_W'(DEPTH - 1))))
                     w_state_next = ST_RUN;
         ST_RUN:  if (i_reload)
                     w_state_next = ST_LOAD;
         default: w_state_next = ST_LOAD;
      endcase
   end

   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!i_rst_n) begin
         r_state       <= SKIP_LOAD ? ST_RUN : ST_LOAD;
         r_wr_ptr      <= '0;
         r_load_count  <= SKIP_LOAD ? CNT_W'(DEPTH) : '0;
         o_fetch_valid <= 1'b0;
         o_fetch_instr <= '0;
         o_fetch_err   <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         o_fetch_valid <= w_fetch_acc;
         if (w_reload_run) begin
            r_wr_ptr     <= '0;
            r_load_count <= '0;
         end else if (w_beat) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_load_count != CNT_W'(DEPTH))
               r_load_count <= r_load_count + 1'b1;
         end
         if (w_fetch_acc) begin
            o_fetch_err   <= w_err;
            o_fetch_instr <= w_err ? DATA_W'(FILL_INSTR) : r_mem[w_idx[PTR_W-1:0]];
         end
      end
   end

   // NOTE: the memory array has no reset so it maps onto block RAM; load_count
   // alone decides which words are readable.
   always_ff @(posedge i_clk) begin
      if (i_rst_n && w_beat)
         r_mem[r_wr_ptr] <= i_load_data;
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader (DEPTH=8, byte addressing).
module tb_imem_boot_loader;

   localparam logic [31:0] FILL = 32'hF800_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_valid;
   logic [31:0] load_data;
   logic        load_last;
   logic        load_ready;
   logic        reload;
   logic        boot_done;
   logic        core_stall;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_valid;
   logic [31:0] fetch_instr;
   logic        fetch_err;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   imem_boot_loader #(
      .DATA_W(32), .DEPTH(8), .ADDR_W(32), .BYTE_ADDR(1'b1), .SKIP_LOAD(1'b0),
      .FILL_INSTR(32'hF800_0000)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_load_valid(load_valid), .i_load_data(load_data), .i_load_last(load_last),
      .o_load_ready(load_ready), .i_reload(reload),
      .o_boot_done(boot_done), .o_core_stall(core_stall),
      .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr),
      .o_fetch_valid(fetch_valid), .o_fetch_instr(fetch_instr), .o_fetch_err(fetch_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance one edge; outputs are sampled 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic v, input logic [31:0] d, input logic last);
      load_valid = v;
      load_data  = d;
      load_last  = last;
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic fetch(input string tag, input logic [31:0] a,
                        input logic [31:0] exp_instr, input logic exp_err);
      fetch_req  = 1'b1;
      fetch_addr = a;
      tick();
      check({tag, "_valid"}, 32'(fetch_valid), 32'd1);
      check({tag, "_instr"}, fetch_instr, exp_instr);
      check({tag, "_err"}, 32'(fetch_err), 32'(exp_err));
   endtask

   task automatic do_reload();
      reload = 1'b1;
      tick();
      reload = 1'b0;
   endtask

   logic [31:0] img [4] = '{32'h4C40_0000, 32'h4C80_0001, 32'h2C00_0000, 32'hF800_0000};

   initial begin
      rst_n = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
      reload = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
      tick();
      tick();
      rst_n = 1'b1;
      check("rst_ready", 32'(load_ready), 32'd1);
      check("rst_done",  32'(boot_done),  32'd0);
      check("rst_stall", 32'(core_stall), 32'd1);
      check("rst_valid", 32'(fetch_valid), 32'd0);
      check("rst_instr", fetch_instr, 32'd0);
      check("rst_err",   32'(fetch_err), 32'd0);

      // Four-word image; boot_done must rise only after the last beat.
      for (int i = 0; i < 4; i++) begin
         beat(1'b1, img[i], i == 3);
         check($sformatf("load4_done%0d", i), 32'(boot_done), (i == 3) ? 32'd1 : 32'd0);
      end
      check("load4_stall", 32'(core_stall), 32'd0);
      check("load4_ready", 32'(load_ready), 32'd0);

      for (int i = 0; i < 4; i++)
         fetch($sformatf("b2b%0d", i), 32'(4 * i), img[i], 1'b0);
      fetch_req = 1'b0;
      tick();
      check("idle_valid", 32'(fetch_valid), 32'd0);

      fetch("unloaded",   32'h0000_0010, FILL, 1'b1);
      fetch("misaligned", 32'h0000_0002, FILL, 1'b1);
      fetch("oor",        32'h0000_0400, FILL, 1'b1);
      fetch("upperbit",   32'h8000_0000, FILL, 1'b1);
      fetch("ok_after",   32'h0000_0008, img[2], 1'b0);

      // Reload with a same-cycle fetch: reload wins.
      reload = 1'b1; fetch_req = 1'b1; fetch_addr = '0;
      tick();
      reload = 1'b0;
      check("rl_valid", 32'(fetch_valid), 32'd0);
      check("rl_ready", 32'(load_ready), 32'd1);
      check("rl_done",  32'(boot_done), 32'd0);

      // Gapped load with fetch_req held; invalid cycles carry junk and load_last.
      beat(1'b1, 32'hA000_0000, 1'b0);
      check("gap0_valid", 32'(fetch_valid), 32'd0);
      beat(1'b0, 32'hDEAD_0001, 1'b1);
      check("gap1_stall", 32'(core_stall), 32'd1);
      check("gap1_valid", 32'(fetch_valid), 32'd0);
      beat(1'b1, 32'hA000_0004, 1'b0);
      check("gap2_stall", 32'(core_stall), 32'd1);
      beat(1'b0, 32'hDEAD_0002, 1'b1);
      check("gap3_stall", 32'(core_stall), 32'd1);
      check("gap3_valid", 32'(fetch_valid), 32'd0);
      beat(1'b1, 32'hA000_0008, 1'b1);
      check("gap4_done", 32'(boot_done), 32'd1);
      check("gap4_valid", 32'(fetch_valid), 32'd0);
      fetch("gapf0", 32'h0, 32'hA000_0000, 1'b0);
      fetch("gapf1", 32'h4, 32'hA000_0004, 1'b0);
      fetch("gapf2", 32'h8, 32'hA000_0008, 1'b0);
      fetch("gapf3", 32'hC, FILL, 1'b1);
      fetch_req = 1'b0;

      // Fill all eight words without load_last; a ninth beat must be refused.
      do_reload();
      for (int i = 0; i < 8; i++) begin
         beat(1'b1, 32'hB000_0000 + 32'(i), 1'b0);
         check($sformatf("full_ready%0d", i), 32'(load_ready), (i == 7) ? 32'd0 : 32'd1);
      end
      check("full_done", 32'(boot_done), 32'd1);
      beat(1'b1, 32'hDEAD_BEEF, 1'b1);
      check("ninth_ready", 32'(load_ready), 32'd0);
      check("ninth_done",  32'(boot_done), 32'd1);
      fetch("full0", 32'h00, 32'hB000_0000, 1'b0);
      fetch("full7", 32'h1C, 32'hB000_0007, 1'b0);
      fetch("full8", 32'h20, FILL, 1'b1);
      fetch_req = 1'b0;

      // Reset in the middle of a load, then a one-word image.
      do_reload();
      beat(1'b1, 32'hC000_0000, 1'b0);
      beat(1'b1, 32'hC000_0001, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mrst_ready", 32'(load_ready), 32'd1);
      check("mrst_done",  32'(boot_done), 32'd0);
      check("mrst_valid", 32'(fetch_valid), 32'd0);
      check("mrst_instr", fetch_instr, 32'd0);
      beat(1'b1, 32'hD000_0000, 1'b1);
      check("mrst_boot", 32'(boot_done), 32'd1);
      fetch("mrst_a4", 32'h4, FILL, 1'b1);
      fetch("mrst_a0", 32'h0, 32'hD000_0000, 1'b0);
      fetch_req = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Parametrised instruction memory for the SimpleRisc core with a streaming boot-load port, a registered fetch port and bounds and alignment checking.
- After reset it accepts a program image word-by-word from the boot source (UART/assembler bridge) and holds the core stalled.
- It then serves fetches with one-cycle latency.
- Reads of unloaded, out-of-range or misaligned locations return a fill instruction and flag an error.
- It sits between the PC/fetch stage and the boot source, and replaces the file-initialised combinational instruction ROM.

## Interface
- DATA_W, 32, instruction width
- DEPTH, 256, number of instruction words
- ADDR_W, 32, fetch address width
- BYTE_ADDR, 1, 1: fetch_addr is a byte address, index = addr>>2, addr[1:0] must be 0; 0: fetch_addr is a word index
- SKIP_LOAD, 0, 1: memory is preloaded at elaboration, the block starts in RUN and all DEPTH words count as loaded
- FILL_INSTR, 32'hF800_0000, word returned on error (hlt)
- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- load_valid  in  1  boot word present
- load_data  in  DATA_W  boot word
- load_last  in  1  final word of the image
- load_ready  out  1  block accepts a boot word
- reload  in  1  single-cycle pulse; restarts loading
- boot_done  out  1  image loaded, block is in RUN
- core_stall  out  1  holds the core while loading (equals !boot_done)
- fetch_req  in  1  fetch request
- fetch_addr  in  ADDR_W  fetch address
- fetch_valid  out  1  fetch_instr/fetch_err are valid this cycle
- fetch_instr  out  DATA_W  fetched instruction
- fetch_err  out  1  fetch was unloaded, out-of-range or misaligned

## Operation
- States: LOAD and RUN. A registered state drives load_ready = (state==LOAD).
- Reset:
  - state = LOAD, or RUN when SKIP_LOAD=1.
  - wr_ptr = 0.
  - load_count = 0, or DEPTH when SKIP_LOAD=1.
  - fetch_valid = 0, fetch_instr = 0, fetch_err = 0.
  - boot_done = SKIP_LOAD, core_stall = !SKIP_LOAD.
  - Memory contents are not cleared.
- LOAD:
  - A beat is accepted when load_valid && load_ready. On a beat: mem[wr_ptr] = load_data, wr_ptr++, load_count++.
  - Go to RUN after an accepted beat with load_last=1, or after the beat written at wr_ptr = DEPTH-1 (memory full). load_ready is 0 from the next cycle.
  - fetch_req is ignored; fetch_valid stays 0.
- RUN:
  - A fetch is accepted when fetch_req is sampled high.
  - idx = BYTE_ADDR ? fetch_addr>>2 : fetch_addr.
  - err = (BYTE_ADDR && fetch_addr[1:0]!=0) || idx >= DEPTH || idx >= load_count.
  - If err: fetch_instr = FILL_INSTR and fetch_err = 1. Otherwise fetch_instr = mem[idx] and fetch_err = 0.
  - Compare idx at full ADDR_W width; truncating to clog2(DEPTH) bits before the compare is not allowed. Any upper address bit set means out of range.
- reload sampled high in RUN: state = LOAD, wr_ptr = 0, load_count = 0, boot_done = 0. reload in LOAD is ignored.
- load_count width is clog2(DEPTH+1) and saturates at DEPTH.
- Boot words received in RUN are not accepted (load_ready = 0) and are never written.

## Timing
- Fetch latency is 1 cycle. fetch_req at edge N gives fetch_valid=1 with data during cycle N+1. Back-to-back requests give valid data every cycle.
- fetch_valid falls to 0 in the cycle after a cycle with no request.
- Load takes 1 word per cycle at full rate. The last beat is accepted at edge N; boot_done=1 and core_stall=0 from cycle N+1.
- The first legal fetch_req is sampled at edge N+1; its data is valid in cycle N+2.
- Simultaneous reload and fetch_req in RUN: reload wins; fetch_valid=0 next cycle.
- Reset mid-load or mid-fetch: all state and outputs return to reset values on that edge. A partially loaded image becomes unreadable because load_count is back to 0.
- Write and fetch never coincide, because they are gated by state. A same-cycle read/write collision cannot occur.

## Test plan
- Load 4 words (0x4C40_0000, 0x4C80_0001, 0x2C00_0000, 0xF800_0000; last on word 3), BYTE_ADDR=1, then fetch addrs 0,4,8,12 back-to-back:
  - boot_done rises the cycle after beat 3.
  - Returned data is the 4 words in order, fetch_valid for 4 consecutive cycles, fetch_err=0.
- Same image, fetch addr 16 (unloaded), 2 (misaligned), 0x0000_0400 (out of range) and 0x1_0000_0000-wrap style upper bit set:
  - Each returns 0xF800_0000 with fetch_err=1.
- Load with load_valid toggling 1,0,1,0 and fetch_req held high during LOAD:
  - Only valid cycles write.
  - fetch_valid stays 0 and core_stall stays 1 until the last beat.
- Stream DEPTH=8 words with load_last never asserted:
  - Transition to RUN after word 7.
  - load_ready=0 afterward, and a 9th beat is not written.
- In RUN assert reload with fetch_req the same cycle:
  - No fetch_valid, load_ready=1 next cycle.
  - A fetch of addr 0 after reloading 1 new word returns the new word.
- Assert rst_n=0 after 2 of 4 load beats, then reload 1 word with last:
  - Fetch addr 4 returns FILL with fetch_err=1.
  - Fetch addr 0 returns the new word.
